interrupt_ack_sequencer: RTL and testbench
==========================================

# interrupt_ack_sequencer

Cycle-based controller that runs the 8086-mode interrupt acknowledge handshake of the PIC. It raises `intOut` to the CPU when the priority resolver reports a pending request, counts the two `intaN` pulses, and strobes the in-service register set. It also drives the vector byte onto the data buffer and issues automatic and command-driven (OCW2) end-of-interrupt clears. It sits between the priority resolver, the in-service register, the control-word registers and the data bus buffer.

## Interface
- `VEC_W`, 8, width of the vector byte and of ICW2/OCW2
- `clk` input 1: single system clock, all state on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `initDone` input 1: ICW sequence complete; block idles while low
- `icw1Write` input 1: one-cycle pulse, re-initialisation started
- `intReq` input 1: priority resolver has an unmasked request above current in-service level
- `intIndex` input 3: level of that request
- `highestIsrIndex` input 3: highest-priority level currently set in ISR
- `icw2` input 8: vector base, bits [7:3] used
- `aeoi` input 1: ICW4 automatic-EOI bit
- `ocw2Write` input 1: one-cycle pulse, new OCW2 value valid
- `ocw2` input 8: operation command word 2
- `intaN` input 1: CPU acknowledge strobe, asynchronous, active-low
- `intOut` output 1: interrupt request to CPU
- `isrSet` output 1: one-cycle pulse, set ISR bit `isrIndex`
- `isrClr` output 1: one-cycle pulse, clear ISR bit `isrIndex`
- `isrIndex` output 3: level for set/clear
- `vectorEn` output 1: data buffer drives `vectorOut`
- `vectorOut` output 8: vector byte
- `seqBusy` output 1: acknowledge sequence in progress (freeze priority resolver)

## Operation
- States: IDLE, REQ, ACK1, GAP, ACK2.
- IDLE: if `initDone` and `intReq`, latch `intIndex` into `curIdx` and go to REQ; `intOut`=1.
- REQ: on a synchronised `intaN` falling edge, go to ACK1 and drop `intOut`.
  - If `intReq` is still high, pulse `isrSet` with `curIdx`.
  - If `intReq` has dropped (spurious request), set `curIdx`=7, set a spurious flag, and do not pulse `isrSet`.
  - `curIdx` stays frozen until IDLE; later `intIndex` changes are ignored.
- ACK1: on the rising edge, go to GAP.
- GAP: on a falling edge, go to ACK2, set `vectorEn`=1 and `vectorOut`={`icw2[7:3]`,`curIdx`}.
- ACK2: on a rising edge, drop `vectorEn`.
  - If `aeoi` is set and the spurious flag is clear, pulse `isrClr` with `curIdx`.
  - Return to IDLE.
- `seqBusy`=1 in REQ, ACK1, GAP and ACK2.
- OCW2 decode, independent of the FSM:
  - `ocw2[7:5]`=001 (non-specific EOI): clear `highestIsrIndex`.
  - `ocw2[7:5]`=011 (specific EOI): clear `ocw2[2:0]`.
  - Any other code: no action.
- `icw1Write` or `initDone`=0 forces IDLE; all outputs go to 0 and a pending EOI is discarded.

## Timing
- Reset values: every output 0, state IDLE, `curIdx`=0, sync flops=1 (`intaN` idle high).
- `intaN` passes through a 2-flop synchroniser. An edge is detected in the cycle the synced value differs from its registered copy.
- Latency:
  - `intReq` → `intOut`: 1 cycle.
  - Edge detect → `isrSet`/`vectorEn`/`isrClr`/`intOut` change: registered, 1 cycle.
  - `intaN` pin → detect: 2–3 cycles.
- The vector is stable from 1 cycle after the second falling-edge detect until 1 cycle after the second rising-edge detect.
- `ocw2Write` → `isrClr`: 1 cycle.
- Simultaneous AEOI clear and OCW2 EOI in the same cycle:
  - AEOI wins.
  - The OCW2 clear is held in a one-entry pending register and issued the next cycle.
  - A second `ocw2Write` while one is pending overwrites it.
- `isrSet` and `isrClr` are never high in the same cycle; `isrClr` defers one cycle if it would coincide.
- An `intaN` edge arriving in IDLE is ignored.
- Async reset mid-sequence immediately returns to reset values.

## Structure
- Shared package `pic_pkg` holds:
  - state enum `ack_state_t`;
  - constants `EOI_NONSPEC`=3'b001 and `EOI_SPEC`=3'b011;
  - `SPURIOUS_LEVEL`=3'd7.
- Sub-module `inta_edge_detect`: 2-flop synchroniser plus registered copy. Outputs `intaFall` and `intaRise` as one-cycle pulses, reset to idle-high.

## Test plan
- `intReq`=1, `intIndex`=5, `icw2`=8'h40, two `intaN` pulses:
  - one `isrSet` with index 5;
  - `vectorOut`=8'h45 while `vectorEn`;
  - `intOut` low after the first pulse;
  - no `isrClr` with `aeoi`=0.
- Same sequence with `aeoi`=1 → `isrClr` index 5 exactly one cycle after the second rising-edge detect.
- `intReq` dropped before the first `intaN` → no `isrSet`, `vectorOut`=8'h47, no `isrClr` even with `aeoi`=1.
- `ocw2Write` with `ocw2`=8'h63 → `isrClr` index 3. With `ocw2`=8'h20 and `highestIsrIndex`=2 → `isrClr` index 2. With `ocw2`=8'hA0 → nothing.
- AEOI clear of level 4 coincides with an `ocw2` 8'h61 write → `isrClr` index 4, then index 1 the next cycle.
- `rst_n` low in GAP → all outputs 0 at once. After release, the next `intaN` pulse is ignored until a new `intReq`.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt acknowledge path: sequencer states,
// OCW2 end-of-interrupt command codes and small decode helpers.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ACK1 = 3'd2,
        ST_GAP  = 3'd3,
        ST_ACK2 = 3'd4
    } ack_state_t;

    localparam logic [2:0] EOI_NONSPEC    = 3'b001;
    localparam logic [2:0] EOI_SPEC       = 3'b011;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    function automatic logic is_eoi_code(input logic [2:0] code);
        return (code == EOI_NONSPEC) || (code == EOI_SPEC);
    endfunction

    // Non-specific EOI clears the highest in-service level, specific EOI names it.
    function automatic logic [2:0] eoi_level(input logic [2:0] code,
                                             input logic [2:0] highest,
                                             input logic [2:0] named);
        return (code == EOI_NONSPEC) ? highest : named;
    endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Synchronises the asynchronous active-low INTA strobe and flags its edges as
// single-cycle pulses. All flops idle high so reset never fakes an edge.
module inta_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic intaN,
    output logic intaFall,
    output logic intaRise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-flop synchroniser followed by a copy used for edge comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= intaN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign intaFall = prev_q & ~sync2_q;
    assign intaRise = ~prev_q & sync2_q;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086-mode interrupt acknowledge sequencer: raises INT, tracks the two INTA
// pulses, sets/clears in-service bits and presents the vector byte.
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             initDone,
    input  logic             icw1Write,
    input  logic             intReq,
    input  logic [2:0]       intIndex,
    input  logic [2:0]       highestIsrIndex,
    input  logic [VEC_W-1:0] icw2,
    input  logic             aeoi,
    input  logic             ocw2Write,
    input  logic [VEC_W-1:0] ocw2,
    input  logic             intaN,
    output logic             intOut,
    output logic             isrSet,
    output logic             isrClr,
    output logic [2:0]       isrIndex,
    output logic             vectorEn,
    output logic [VEC_W-1:0] vectorOut,
    output logic             seqBusy
);

    logic inta_fall_s;
    logic inta_rise_s;

    inta_edge_detect u_inta_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .intaN    (intaN),
        .intaFall (inta_fall_s),
        .intaRise (inta_rise_s)
    );

    ack_state_t       state_q,      state_d;
    logic [2:0]       cur_idx_q,    cur_idx_d;
    logic             spurious_q,   spurious_d;
    logic             int_out_q,    int_out_d;
    logic             vector_en_q,  vector_en_d;
    logic [VEC_W-1:0] vector_out_q, vector_out_d;
    logic             isr_set_q,    isr_set_d;
    logic             isr_clr_q,    isr_clr_d;
    logic [2:0]       isr_index_q,  isr_index_d;
    logic             seq_busy_q,   seq_busy_d;
    logic             pend_valid_q, pend_valid_d;
    logic [2:0]       pend_idx_q,   pend_idx_d;

    logic       force_idle_s;
    logic       set_s;
    logic       aeoi_clr_s;
    logic       ocw_req_s;
    logic [2:0] ocw_code_s;
    logic [2:0] ocw_idx_s;
    logic       clr_s;
    logic [2:0] clr_idx_s;
    logic       unused_bits_s;

    assign force_idle_s  = icw1Write | ~initDone;
    assign ocw_code_s    = ocw2[VEC_W-1 -: 3];
    assign ocw_req_s     = ocw2Write & is_eoi_code(ocw_code_s);
    assign ocw_idx_s     = eoi_level(ocw_code_s, highestIsrIndex, ocw2[2:0]);
    assign unused_bits_s = ^{icw2[2:0], ocw2[4:3]};

    // Acknowledge handshake state machine.
    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        spurious_d   = spurious_q;
        int_out_d    = int_out_q;
        vector_en_d  = vector_en_q;
        vector_out_d = vector_out_q;
        set_s        = 1'b0;
        aeoi_clr_s   = 1'b0;
        if (force_idle_s) begin
            state_d      = ST_IDLE;
            cur_idx_d    = 3'd0;
            spurious_d   = 1'b0;
            int_out_d    = 1'b0;
            vector_en_d  = 1'b0;
            vector_out_d = {VEC_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (intReq) begin
                        state_d    = ST_REQ;
                        cur_idx_d  = intIndex;
                        spurious_d = 1'b0;
                        int_out_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (inta_fall_s) begin
                        state_d   = ST_ACK1;
                        int_out_d = 1'b0;
                        if (intReq) begin
                            set_s = 1'b1;
                        end else begin
                            // Request vanished before acknowledge: answer with level 7.
                            cur_idx_d  = SPURIOUS_LEVEL;
                            spurious_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_ACK1: begin
                    if (inta_rise_s) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ACK1;
                    end
                end
                ST_GAP: begin
                    if (inta_fall_s) begin
                        state_d      = ST_ACK2;
                        vector_en_d  = 1'b1;
                        vector_out_d = {icw2[VEC_W-1:3], cur_idx_q};
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_ACK2: begin
                    if (inta_rise_s) begin
                        state_d      = ST_IDLE;
                        vector_en_d  = 1'b0;
                        vector_out_d = {VEC_W{1'b0}};
                        aeoi_clr_s   = aeoi & ~spurious_q;
                    end else begin
                        state_d = ST_ACK2;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    int_out_d    = 1'b0;
                    vector_en_d  = 1'b0;
                    vector_out_d = {VEC_W{1'b0}};
                end
            endcase
        end
    end

    // ISR clear arbitration: set beats clear, AEOI beats a pending OCW2 EOI,
    // which in turn beats a fresh OCW2 EOI; losers wait in the one-entry slot.
    always_comb begin
        clr_s        = 1'b0;
        clr_idx_s    = 3'd0;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        if (force_idle_s) begin
            pend_valid_d = 1'b0;
            pend_idx_d   = 3'd0;
        end else if (set_s || aeoi_clr_s) begin
            clr_s     = aeoi_clr_s;
            clr_idx_s = aeoi_clr_s ? cur_idx_q : 3'd0;
            if (ocw_req_s) begin
                pend_valid_d = 1'b1;
                pend_idx_d   = ocw_idx_s;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end else if (pend_valid_q) begin
            clr_s        = 1'b1;
            clr_idx_s    = pend_idx_q;
            pend_valid_d = ocw_req_s;
            pend_idx_d   = ocw_req_s ? ocw_idx_s : pend_idx_q;
        end else if (ocw_req_s) begin
            clr_s     = 1'b1;
            clr_idx_s = ocw_idx_s;
        end else begin
            clr_s = 1'b0;
        end
    end

    // Output next-state values.
    always_comb begin
        isr_set_d  = set_s;
        isr_clr_d  = clr_s;
        seq_busy_d = (state_d != ST_IDLE);
        if (set_s) begin
            isr_index_d = cur_idx_q;
        end else if (clr_s) begin
            isr_index_d = clr_idx_s;
        end else begin
            isr_index_d = 3'd0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_idx_q    <= 3'd0;
            spurious_q   <= 1'b0;
            int_out_q    <= 1'b0;
            vector_en_q  <= 1'b0;
            vector_out_q <= {VEC_W{1'b0}};
            isr_set_q    <= 1'b0;
            isr_clr_q    <= 1'b0;
            isr_index_q  <= 3'd0;
            seq_busy_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            spurious_q   <= spurious_d;
            int_out_q    <= int_out_d;
            vector_en_q  <= vector_en_d;
            vector_out_q <= vector_out_d;
            isr_set_q    <= isr_set_d;
            isr_clr_q    <= isr_clr_d;
            isr_index_q  <= isr_index_d;
            seq_busy_q   <= seq_busy_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
        end
    end

    assign intOut    = int_out_q;
    assign isrSet    = isr_set_q;
    assign isrClr    = isr_clr_q;
    assign isrIndex  = isr_index_q;
    assign vectorEn  = vector_en_q;
    assign vectorOut = vector_out_q;
    assign seqBusy   = seq_busy_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: INTA handshakes, AEOI, spurious
// requests, OCW2 EOIs with arbitration, forced idle and mid-sequence reset.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       initDone;
    logic       icw1Write;
    logic       intReq;
    logic [2:0] intIndex;
    logic [2:0] highestIsrIndex;
    logic [7:0] icw2;
    logic       aeoi;
    logic       ocw2Write;
    logic [7:0] ocw2;
    logic       intaN;
    logic       intOut;
    logic       isrSet;
    logic       isrClr;
    logic [2:0] isrIndex;
    logic       vectorEn;
    logic [7:0] vectorOut;
    logic       seqBusy;

    int vectors = 0;
    int errors  = 0;

    interrupt_ack_sequencer #(.VEC_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .initDone        (initDone),
        .icw1Write       (icw1Write),
        .intReq          (intReq),
        .intIndex        (intIndex),
        .highestIsrIndex (highestIsrIndex),
        .icw2            (icw2),
        .aeoi            (aeoi),
        .ocw2Write       (ocw2Write),
        .ocw2            (ocw2),
        .intaN           (intaN),
        .intOut          (intOut),
        .isrSet          (isrSet),
        .isrClr          (isrClr),
        .isrIndex        (isrIndex),
        .vectorEn        (vectorEn),
        .vectorOut       (vectorOut),
        .seqBusy         (seqBusy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the INTA pin and wait until the resulting registered outputs show.
    task automatic inta(input logic v);
        intaN = v;
        tick();
        tick();
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; initDone = 1'b0; icw1Write = 1'b0; intReq = 1'b0;
        intIndex = 3'd0; highestIsrIndex = 3'd0; icw2 = 8'h00; aeoi = 1'b0;
        ocw2Write = 1'b0; ocw2 = 8'h00; intaN = 1'b1;
        tick(); tick();
        chk("rst_intOut", intOut, 1'b0);
        chk("rst_isrSet", isrSet, 1'b0);
        chk("rst_isrClr", isrClr, 1'b0);
        chk("rst_isrIndex", isrIndex, 3'd0);
        chk("rst_vectorEn", vectorEn, 1'b0);
        chk("rst_vectorOut", vectorOut, 8'h00);
        chk("rst_seqBusy", seqBusy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic handshake, level 5, no AEOI
        intReq = 1'b1; intIndex = 3'd5; icw2 = 8'h40;
        tick(); tick();
        chk("noinit_intOut", intOut, 1'b0);
        initDone = 1'b1;
        tick();
        chk("t1_intOut_up", intOut, 1'b1);
        chk("t1_busy", seqBusy, 1'b1);
        intaN = 1'b0; tick(); tick();
        chk("t1_intOut_hold", intOut, 1'b1);
        tick();
        chk("t1_intOut_low", intOut, 1'b0);
        chk("t1_isrSet", isrSet, 1'b1);
        chk("t1_isrIndex", isrIndex, 3'd5);
        intReq = 1'b0;
        tick();
        chk("t1_isrSet_pulse", isrSet, 1'b0);
        inta(1'b1);
        chk("t1_gap_vecEn", vectorEn, 1'b0);
        intIndex = 3'd2;
        intaN = 1'b0; tick(); tick();
        chk("t1_vecEn_early", vectorEn, 1'b0);
        tick();
        chk("t1_vecEn", vectorEn, 1'b1);
        chk("t1_vector", vectorOut, 8'h45);
        intaN = 1'b1; tick(); tick();
        chk("t1_vector_hold", vectorOut, 8'h45);
        tick();
        chk("t1_vecEn_drop", vectorEn, 1'b0);
        chk("t1_noclr", isrClr, 1'b0);
        chk("t1_busy_done", seqBusy, 1'b0);
        tick();
        chk("t1_noclr2", isrClr, 1'b0);

        // AEOI, level 5, with an OCW2 write colliding with isrSet
        aeoi = 1'b1; intReq = 1'b1; intIndex = 3'd5;
        tick();
        chk("t2_intOut", intOut, 1'b1);
        intaN = 1'b0; tick(); tick();
        ocw2 = 8'h63; ocw2Write = 1'b1;
        tick();
        ocw2Write = 1'b0; intReq = 1'b0;
        chk("t2_isrSet", isrSet, 1'b1);
        chk("t2_set_noclr", isrClr, 1'b0);
        chk("t2_set_idx", isrIndex, 3'd5);
        tick();
        chk("t2_defer_clr", isrClr, 1'b1);
        chk("t2_defer_idx", isrIndex, 3'd3);
        chk("t2_defer_noset", isrSet, 1'b0);
        inta(1'b1);
        inta(1'b0);
        chk("t2_vector", vectorOut, 8'h45);
        intaN = 1'b1; tick(); tick();
        chk("t2_clr_early", isrClr, 1'b0);
        tick();
        chk("t2_aeoi_clr", isrClr, 1'b1);
        chk("t2_aeoi_idx", isrIndex, 3'd5);
        tick();
        chk("t2_clr_pulse", isrClr, 1'b0);

        // Spurious request: intReq drops before the first INTA
        intReq = 1'b1; intIndex = 3'd2;
        tick();
        intReq = 1'b0;
        inta(1'b0);
        chk("t3_noset", isrSet, 1'b0);
        chk("t3_intOut", intOut, 1'b0);
        chk("t3_busy", seqBusy, 1'b1);
        inta(1'b1);
        inta(1'b0);
        chk("t3_vector", vectorOut, 8'h47);
        inta(1'b1);
        chk("t3_noclr", isrClr, 1'b0);
        chk("t3_vecEn", vectorEn, 1'b0);
        tick();
        chk("t3_noclr2", isrClr, 1'b0);
        aeoi = 1'b0;

        // OCW2 command decode
        ocw2 = 8'h63; ocw2Write = 1'b1; tick(); ocw2Write = 1'b0;
        chk("ocw_spec_clr", isrClr, 1'b1);
        chk("ocw_spec_idx", isrIndex, 3'd3);
        tick();
        chk("ocw_spec_pulse", isrClr, 1'b0);
        ocw2 = 8'h20; highestIsrIndex = 3'd2; ocw2Write = 1'b1; tick(); ocw2Write = 1'b0;
        chk("ocw_nonspec_clr", isrClr, 1'b1);
        chk("ocw_nonspec_idx", isrIndex, 3'd2);
        ocw2 = 8'hA0; ocw2Write = 1'b1; tick(); ocw2Write = 1'b0;
        chk("ocw_other_none", isrClr, 1'b0);
        tick();
        chk("ocw_other_none2", isrClr, 1'b0);

        // AEOI clear of level 4 coinciding with a specific EOI of level 1
        aeoi = 1'b1; intReq = 1'b1; intIndex = 3'd4;
        tick();
        inta(1'b0);
        chk("t5_isrSet_idx", isrIndex, 3'd4);
        intReq = 1'b0;
        inta(1'b1);
        inta(1'b0);
        intaN = 1'b1; tick(); tick();
        ocw2 = 8'h61; ocw2Write = 1'b1;
        tick();
        ocw2Write = 1'b0;
        chk("t5_aeoi_clr", isrClr, 1'b1);
        chk("t5_aeoi_idx", isrIndex, 3'd4);
        tick();
        chk("t5_ocw_clr", isrClr, 1'b1);
        chk("t5_ocw_idx", isrIndex, 3'd1);
        tick();
        chk("t5_clr_done", isrClr, 1'b0);
        aeoi = 1'b0;

        // icw1Write forces idle; a following INTA is ignored
        intReq = 1'b1; intIndex = 3'd3;
        tick();
        chk("t6_intOut", intOut, 1'b1);
        intReq = 1'b0; icw1Write = 1'b1;
        tick();
        icw1Write = 1'b0;
        chk("t6_forced_intOut", intOut, 1'b0);
        chk("t6_forced_busy", seqBusy, 1'b0);
        inta(1'b0);
        chk("t6_ignored_set", isrSet, 1'b0);
        inta(1'b1);

        // Async reset while in GAP
        intReq = 1'b1; intIndex = 3'd6;
        tick();
        inta(1'b0);
        intReq = 1'b0;
        inta(1'b1);
        chk("t7_gap_busy", seqBusy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_busy", seqBusy, 1'b0);
        chk("t7_rst_intOut", intOut, 1'b0);
        chk("t7_rst_vecEn", vectorEn, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        inta(1'b0);
        chk("t7_ignored_set", isrSet, 1'b0);
        chk("t7_ignored_busy", seqBusy, 1'b0);
        inta(1'b1);
        intReq = 1'b1; intIndex = 3'd1;
        tick();
        chk("t7_new_intOut", intOut, 1'b1);
        inta(1'b0);
        chk("t7_new_set", isrSet, 1'b1);
        chk("t7_new_idx", isrIndex, 3'd1);
        intReq = 1'b0;
        inta(1'b1);
        inta(1'b0);
        chk("t7_new_vector", vectorOut, 8'h41);
        inta(1'b1);
        chk("t7_end_busy", seqBusy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
